// File: rtl/fifo_burst_reader.sv
// Read-side burst master for the synchronous FIFO: drains burst_len words into a
// 3-entry skid buffer and presents them on a valid/ready stream, pulsing done at the end.
module fifo_burst_reader #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] burst_len,
  output logic             busy,
  output logic             done,
  input  logic             empty,
  input  logic [WIDTH-1:0] data_out,
  output logic             RD_EN,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [1:0]       count_q, count_d;
  logic [1:0]       wr_ptr_q, rd_ptr_q;
  logic             inflight_q;
  logic             done_q, done_d;
  logic [WIDTH-1:0] mem_q [3];
  logic             push, pop, rd_en;
  logic [2:0]       occupancy;

  function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
    return (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
  endfunction

  assign m_valid   = (count_q != 2'd0);
  assign m_data    = mem_q[rd_ptr_q];
  assign pop       = m_valid && m_ready;
  // A read issued last cycle lands in the buffer this cycle, whatever m_ready does.
  assign push      = inflight_q;
  assign occupancy = {1'b0, count_q} + {2'b00, inflight_q};

  // Registers and empty only: a slot is reserved for every word still in flight.
  assign rd_en = (state_q == StRead) && !empty && (remaining_q != '0) && (occupancy <= 3'd2);

  assign RD_EN = rd_en;
  assign busy  = (state_q != StIdle);
  assign done  = done_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (burst_len != '0) begin
            remaining_d = burst_len;
            state_d     = StRead;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StRead: begin
        if (rd_en) begin
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // Leave as the last buffered word is handed off, so done follows that handshake.
        if (!inflight_q && (count_d == 2'd0)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      count_q     <= 2'd0;
      wr_ptr_q    <= 2'd0;
      rd_ptr_q    <= 2'd0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      count_q     <= count_d;
      inflight_q  <= rd_en;
      done_q      <= done_d;
      if (push) begin
        mem_q[wr_ptr_q] <= data_out;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: queue-based FIFO model, expected-word scoreboard,
// table of randomized bursts plus cycle-exact hand sequences.
module tb_fifo_burst_reader;

  logic        clk = 1'b0;
  logic        rst, start, empty, m_ready;
  logic [7:0]  burst_len;
  logic [31:0] data_out;
  logic        busy, done, rd_en, m_valid;
  logic [31:0] m_data;

  always #5 clk = ~clk;

  fifo_burst_reader #(.WIDTH(32), .LEN_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .burst_len (burst_len),
    .busy      (busy),
    .done      (done),
    .empty     (empty),
    .data_out  (data_out),
    .RD_EN     (rd_en),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready)
  );

  typedef struct {
    int len;
    int ready_pct;
    int empty_mode;
    int restart_at;
    int exp_hs;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          seq = 0;
  logic [31:0] fifo_q[$];
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  logic        empty_gate;
  logic        s_rd, s_valid, s_busy, s_done;
  logic [31:0] s_data;
  bit          mon = 0;
  int          rd_cnt, done_cnt, last_hs_cyc;
  logic        prev_stall;
  logic [31:0] prev_data;
  vec_t        vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: present empty, sample at negedge, then let the FIFO model answer reads.
  task automatic tick();
    empty = empty_gate || (fifo_q.size() == 0);
    @(negedge clk);
    s_rd    = rd_en;
    s_valid = m_valid;
    s_data  = m_data;
    s_busy  = busy;
    s_done  = done;
    if (mon) begin
      chk("rd_while_empty", 32'(s_rd && empty), 0);
      if (prev_stall) begin
        chk("hold_valid", 32'(s_valid), 1);
        chk("hold_data", s_data, prev_data);
      end
      if (s_rd === 1'b1) rd_cnt++;
      if (s_valid && m_ready) begin
        got_q.push_back(s_data);
        last_hs_cyc = cyc;
      end
      chk("occupancy", 32'((rd_cnt - got_q.size()) > 3), 0);
      if (s_done === 1'b1) begin
        done_cnt++;
        if (got_q.size() != 0) chk("done_timing", cyc, last_hs_cyc + 1);
        chk("done_not_busy", 32'(s_busy), 0);
      end
      prev_stall = s_valid && !m_ready;
      prev_data  = s_data;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (s_rd === 1'b1 && fifo_q.size() != 0) data_out = fifo_q.pop_front();
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back({16'(seq), 16'($urandom())});
      seq++;
    end
  endtask

  task automatic begin_mon(input int len);
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < len && i < fifo_q.size(); i++) exp_q.push_back(fifo_q[i]);
    rd_cnt      = 0;
    done_cnt    = 0;
    last_hs_cyc = -1;
    prev_stall  = 1'b0;
    mon         = 1;
  endtask

  task automatic set_stim(input int ready_pct, input int empty_mode);
    m_ready = ($urandom_range(99) < ready_pct);
    case (empty_mode)
      1:       empty_gate = ((cyc % 2) == 1);
      2:       empty_gate = ($urandom_range(99) < 30);
      default: empty_gate = 1'b0;
    endcase
  endtask

  task automatic finish_burst(input int len, input int ready_pct, input int empty_mode,
                              input int restart_at);
    int budget = len * 12 + 40;
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      set_stim(ready_pct, empty_mode);
      start = (n + 1 == restart_at);
      if (start) burst_len = 8'd2;
      tick();
      n++;
    end
    start      = 1'b0;
    m_ready    = 1'b1;
    empty_gate = 1'b0;
    repeat (3) tick();
    mon = 0;
    chk("handshakes", got_q.size(), len);
    for (int i = 0; i < len && i < got_q.size(); i++) chk("order", got_q[i], exp_q[i]);
    chk("rd_count", rd_cnt, len);
    chk("done_pulses", done_cnt, 1);
    chk("idle_after", 32'({s_busy, s_valid, s_rd, s_done}), 0);
    chk("fifo_left", fifo_q.size(), 2);
    fifo_q.delete();
  endtask

  task automatic run_burst(input vec_t v);
    fill(v.len + 2);
    begin_mon(v.exp_hs);
    set_stim(v.ready_pct, v.empty_mode);
    start     = 1'b1;
    burst_len = 8'(v.len);
    tick();
    start = 1'b0;
    finish_burst(v.exp_hs, v.ready_pct, v.empty_mode, v.restart_at);
  endtask

  initial begin
    vecs[0] = '{6, 100, 1, -1, 6};
    vecs[1] = '{1, 100, 0, -1, 1};
    vecs[2] = '{3, 50, 2, -1, 3};
    vecs[3] = '{20, 30, 2, -1, 20};
    vecs[4] = '{8, 100, 0, 3, 8};
    vecs[5] = '{255, 50, 0, -1, 255};

    rst        = 1'b1;
    start      = 1'b0;
    burst_len  = 8'd0;
    m_ready    = 1'b0;
    empty_gate = 1'b0;
    data_out   = 32'd0;
    tick();
    tick();
    chk("rst_rd_en", 32'(s_rd), 0);
    chk("rst_valid", 32'(s_valid), 0);
    chk("rst_data", s_data, 0);
    chk("rst_busy", 32'(s_busy), 0);
    chk("rst_done", 32'(s_done), 0);
    rst = 1'b0;
    tick();

    // Cycle-exact burst of four with the stream always ready.
    fifo_q = '{32'd11, 32'd22, 32'd33, 32'd44};
    begin_mon(4);
    m_ready   = 1'b1;
    start     = 1'b1;
    burst_len = 8'd4;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk("t_rd", 32'(s_rd), 32'(c >= 1 && c <= 4));
      chk("t_valid", 32'(s_valid), 32'(c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) chk("t_data", s_data, 32'(11 * (c - 2)));
      chk("t_done", 32'(s_done), 32'(c == 7));
      chk("t_busy", 32'(s_busy), 32'(c <= 6));
    end
    mon = 0;
    chk("t_hs", got_q.size(), 4);

    // Stalled consumer: reads stop once the buffer is committed, head word held.
    fill(7);
    begin_mon(5);
    m_ready   = 1'b0;
    start     = 1'b1;
    burst_len = 8'd5;
    tick();
    start = 1'b0;
    for (int c = 1; c < 8; c++) begin
      tick();
      if (c >= 3) begin
        chk("stall_valid", 32'(s_valid), 1);
        chk("stall_data", s_data, exp_q[0]);
      end
    end
    chk("stall_reads", rd_cnt, 3);
    finish_burst(5, 100, 0, -1);

    // Zero-length request completes immediately without touching the FIFO.
    start     = 1'b1;
    burst_len = 8'd0;
    tick();
    start = 1'b0;
    tick();
    chk("z_done", 32'(s_done), 1);
    chk("z_busy", 32'(s_busy), 0);
    chk("z_rd", 32'(s_rd), 0);
    chk("z_valid", 32'(s_valid), 0);
    tick();
    chk("z_done_clear", 32'(s_done), 0);
    chk("z_busy_after", 32'(s_busy), 0);

    for (int i = 0; i < 6; i++) run_burst(vecs[i]);

    // Reset mid-burst, then a fresh short burst.
    fill(10);
    begin_mon(8);
    m_ready   = 1'b1;
    start     = 1'b1;
    burst_len = 8'd8;
    tick();
    start = 1'b0;
    for (int n = 0; n < 40 && got_q.size() < 2; n++) tick();
    chk("pre_rst_hs", got_q.size(), 2);
    mon = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("mid_rst_rd", 32'(s_rd), 0);
    chk("mid_rst_valid", 32'(s_valid), 0);
    chk("mid_rst_data", s_data, 0);
    chk("mid_rst_busy", 32'(s_busy), 0);
    chk("mid_rst_done", 32'(s_done), 0);
    fifo_q.delete();
    run_burst('{3, 100, 0, -1, 3});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
